// File: rtl/qeciphy_rx_channeldecoder.sv
// qeciphy_rx_channeldecoder: frame alignment, XOR frame check and user-data extraction for the RX word stream
// Ports:
//   clk_i, rst_i                       clock, asynchronous active-high reset
//   s_axis_tdata_i, s_axis_tvalid_i    deserialized word stream (no backpressure)
//   link_enable_i                      low holds the aligner in SEARCH
//   m_axis_tdata_o, m_axis_tvalid_o    recovered data slots, one cycle after input
//   locked_o, remote_rx_rdy_o          alignment status and far-end ready bit
//   crc_error_o, faw_error_o           single-cycle error pulses
module qeciphy_rx_channeldecoder #(
  parameter int          FAW_PERIOD   = 64,
  parameter logic [55:0] FAW_PATTERN  = 56'h5AC3960FF069A5,
  parameter int          LOCK_COUNT   = 3,
  parameter int          UNLOCK_COUNT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] s_axis_tdata_i,
  input  logic        s_axis_tvalid_i,
  input  logic        link_enable_i,
  output logic [63:0] m_axis_tdata_o,
  output logic        m_axis_tvalid_o,
  output logic        locked_o,
  output logic        remote_rx_rdy_o,
  output logic        crc_error_o,
  output logic        faw_error_o
);
  localparam int PW = $clog2(FAW_PERIOD);
  localparam logic [PW-1:0] LAST = PW'(FAW_PERIOD - 1);
  localparam logic [7:0] LOCK_N = 8'(LOCK_COUNT);
  localparam logic [7:0] UNLOCK_N = 8'(UNLOCK_COUNT);
  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;
  state_t state, state_n;
  logic [PW-1:0] pos;
  logic [7:0] good_cnt, miss_cnt;
  logic [63:0] acc, data_q;
  logic active, rdy, valid_q, crc_q, faw_q;
  logic faw, at_faw, at_chk, fwd;
  always_comb begin
    faw = s_axis_tdata_i[63:8] == FAW_PATTERN;
    at_faw = pos == '0;
    at_chk = pos == LAST;
    fwd = state == LOCKED && active && !at_faw && !at_chk;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= SEARCH;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (!link_enable_i) state_n = SEARCH;
    else if (s_axis_tvalid_i)
      case (state)
        SEARCH: state_n = faw ? VERIFY : SEARCH;
        VERIFY: state_n = !at_faw ? VERIFY : !faw ? SEARCH : (good_cnt + 8'd1 == LOCK_N) ? LOCKED : VERIFY;
        LOCKED: state_n = (at_faw && !faw && miss_cnt + 8'd1 == UNLOCK_N) ? SEARCH : LOCKED;
        default: state_n = SEARCH;
      endcase
  end
  always_comb begin
    locked_o = state == LOCKED;
    remote_rx_rdy_o = rdy;
    m_axis_tdata_o = data_q;
    m_axis_tvalid_o = valid_q;
    crc_error_o = crc_q;
    faw_error_o = faw_q;
  end
  // Everything below only leaves SEARCH through a FAW match; any exit from LOCKED
  // clears rdy/active in the same edge that drops locked_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pos <= '0;
      good_cnt <= '0;
      miss_cnt <= '0;
      acc <= '0;
      data_q <= '0;
      active <= 1'b0;
      rdy <= 1'b0;
      valid_q <= 1'b0;
      crc_q <= 1'b0;
      faw_q <= 1'b0;
    end else if (!link_enable_i) begin
      pos <= '0;
      good_cnt <= '0;
      miss_cnt <= '0;
      acc <= '0;
      data_q <= '0;
      active <= 1'b0;
      rdy <= 1'b0;
      valid_q <= 1'b0;
      crc_q <= 1'b0;
      faw_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      crc_q <= 1'b0;
      faw_q <= 1'b0;
      if (s_axis_tvalid_i) begin
        pos <= state_n == SEARCH ? '0 : state == SEARCH ? PW'(1) : at_chk ? '0 : pos + PW'(1);
        good_cnt <= state_n == SEARCH ? 8'd0 : state == SEARCH ? 8'd1 :
                    (state == VERIFY && at_faw) ? good_cnt + 8'd1 : good_cnt;
        miss_cnt <= state_n != LOCKED ? 8'd0 : at_faw ? (faw ? 8'd0 : miss_cnt + 8'd1) : miss_cnt;
        // Only data slots feed the accumulator; FAW and check word restart it.
        acc <= (state == SEARCH || at_faw || at_chk) ? '0 : acc ^ s_axis_tdata_i;
        rdy <= state_n != LOCKED ? 1'b0 : (at_faw && faw) ? s_axis_tdata_i[0] : rdy;
        active <= state_n != LOCKED ? 1'b0 : at_faw ? (faw & s_axis_tdata_i[1]) : active;
        faw_q <= state == LOCKED && at_faw && !faw;
        crc_q <= state == LOCKED && at_chk && s_axis_tdata_i != acc;
        valid_q <= fwd;
        if (fwd) data_q <= s_axis_tdata_i;
      end
    end
  end
endmodule

// File: tb/tb_qeciphy_rx_channeldecoder.sv
// tb_qeciphy_rx_channeldecoder: directed scoreboard bench for the RX channel decoder
module tb_qeciphy_rx_channeldecoder;
  localparam logic [55:0] FAW = 56'h5AC3960FF069A5;
  typedef struct packed {
    logic v;
    logic [63:0] d;
    logic crc;
    logic ferr;
    logic lk;
    logic rdy;
  } exp_t;
  logic clk = 0, rst = 1, en = 1, tvalid = 0;
  logic [63:0] tdata = '0;
  logic [63:0] m_tdata;
  logic m_tvalid, locked, rdy_o, crc_err, faw_err;
  exp_t q[$];
  int checks = 0, errors = 0;
  logic cur_lk = 0, cur_rdy = 0, gap_en = 0;
  qeciphy_rx_channeldecoder dut (
    .clk_i(clk), .rst_i(rst), .s_axis_tdata_i(tdata), .s_axis_tvalid_i(tvalid),
    .link_enable_i(en), .m_axis_tdata_o(m_tdata), .m_axis_tvalid_o(m_tvalid),
    .locked_o(locked), .remote_rx_rdy_o(rdy_o), .crc_error_o(crc_err), .faw_error_o(faw_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask
  function automatic exp_t mk(input logic v, input logic [63:0] d, input logic crc, input logic ferr);
    exp_t e;
    e.v = v;
    e.d = d;
    e.crc = crc;
    e.ferr = ferr;
    e.lk = cur_lk;
    e.rdy = cur_rdy;
    return e;
  endfunction
  task automatic score;
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard: observed empty queue expected one entry");
    end else begin
      e = q.pop_front();
      chk("tvalid", 64'(m_tvalid), 64'(e.v));
      if (e.v) chk("tdata", m_tdata, e.d);
      chk("crc_error", 64'(crc_err), 64'(e.crc));
      chk("faw_error", 64'(faw_err), 64'(e.ferr));
      chk("locked", 64'(locked), 64'(e.lk));
      chk("remote_rx_rdy", 64'(rdy_o), 64'(e.rdy));
    end
  endtask
  task automatic step(input logic [63:0] d, input logic v, input exp_t e);
    @(negedge clk);
    tdata = d;
    tvalid = v;
    q.push_back(e);
    @(posedge clk);
    #1;
    score();
  endtask
  task automatic gap;
    if (gap_en && $urandom_range(0, 3) == 0) step({$urandom, $urandom}, 1'b0, mk(0, '0, 0, 0));
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_tvalid"}, 64'(m_tvalid), 64'd0);
    chk({tag, "_tdata"}, m_tdata, 64'd0);
    chk({tag, "_locked"}, 64'(locked), 64'd0);
    chk({tag, "_rdy"}, 64'(rdy_o), 64'd0);
    chk({tag, "_crc"}, 64'(crc_err), 64'd0);
    chk({tag, "_faw"}, 64'(faw_err), 64'd0);
  endtask
  task automatic data_words(input int n, input logic fwd);
    logic [63:0] d;
    for (int i = 0; i < n; i++) begin
      d = {$urandom, $urandom};
      step(d, 1'b1, mk(fwd, d, 0, 0));
    end
  endtask
  // One full frame: FAW (good or corrupted), 62 data slots, XOR check word.
  // corrupt flips a data slot after the check word was computed; dslot puts a FAW pattern in a data slot.
  task automatic frame(input logic good, input logic [1:0] st, input int corrupt, input int dslot,
                       input logic fwd, input logic ferr, input logic crc, input logic lk, input logic rdy);
    logic [63:0] w, s, acc;
    acc = '0;
    gap();
    w = good ? {FAW, 6'b0, st} : {FAW ^ 56'h100, 6'b0, st};
    cur_lk = lk;
    cur_rdy = rdy;
    step(w, 1'b1, mk(0, '0, 0, ferr));
    for (int i = 1; i <= 62; i++) begin
      gap();
      w = (i == dslot) ? {FAW, 8'h03} : {$urandom, $urandom};
      acc ^= w;
      s = (i == corrupt) ? w ^ 64'h1 : w;
      step(s, 1'b1, mk(fwd, s, 0, 0));
    end
    gap();
    step(acc, 1'b1, mk(0, '0, crc, 0));
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 0;
    gap_en = 1;
    for (int i = 17; i < 64; i++) begin
      gap();
      step({$urandom, $urandom}, 1'b1, mk(0, '0, 0, 0));
    end
    frame(1, 2'b11, -1, -1, 0, 0, 0, 0, 0);
    frame(1, 2'b11, -1, -1, 0, 0, 0, 0, 0);
    frame(1, 2'b11, -1, -1, 1, 0, 0, 1, 1);
    frame(1, 2'b11, -1, -1, 1, 0, 0, 1, 1);
    frame(1, 2'b11, 10, -1, 1, 0, 1, 1, 1);
    gap_en = 0;
    repeat (3) frame(0, 2'b11, -1, -1, 0, 1, 0, 1, 1);
    frame(1, 2'b11, -1, -1, 1, 0, 0, 1, 1);
    repeat (3) frame(0, 2'b11, -1, -1, 0, 1, 0, 1, 1);
    frame(0, 2'b11, -1, -1, 0, 1, 0, 0, 0);
    frame(1, 2'b01, -1, -1, 0, 0, 0, 0, 0);
    frame(1, 2'b01, -1, -1, 0, 0, 0, 0, 0);
    frame(1, 2'b01, -1, -1, 0, 0, 0, 1, 1);
    frame(1, 2'b01, -1, -1, 0, 0, 0, 1, 1);
    frame(1, 2'b11, -1, 20, 1, 0, 0, 1, 1);
    step({FAW, 8'h03}, 1'b1, mk(0, '0, 0, 0));
    data_words(5, 1);
    cur_lk = 0;
    cur_rdy = 0;
    en = 0;
    step({$urandom, $urandom}, 1'b1, mk(0, '0, 0, 0));
    en = 1;
    data_words(20, 0);
    frame(1, 2'b11, -1, -1, 0, 0, 0, 0, 0);
    frame(1, 2'b11, -1, -1, 0, 0, 0, 0, 0);
    frame(1, 2'b11, -1, -1, 1, 0, 0, 1, 1);
    step({FAW, 8'h03}, 1'b1, mk(0, '0, 0, 0));
    data_words(7, 1);
    @(negedge clk);
    rst = 1;
    #1;
    check_zero("midframe_reset");
    @(negedge clk);
    rst = 0;
    cur_lk = 0;
    cur_rdy = 0;
    data_words(30, 0);
    frame(1, 2'b11, -1, -1, 0, 0, 0, 0, 0);
    frame(1, 2'b11, -1, -1, 0, 0, 0, 0, 0);
    frame(1, 2'b11, -1, -1, 1, 0, 0, 1, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/qeciphy_rx_channeldecoder.md
QECIPHY_RX_CHANNELDECODER -- requirements
Module: qeciphy_rx_channeldecoder

Interface
REQ-001 Parameter FAW_PERIOD, default 64: words per frame; word 0 is the FAW, words 1..FAW_PERIOD-2 are data slots, word FAW_PERIOD-1 is the check word.
REQ-002 Parameter FAW_PATTERN, 56 bits, default 56'h5AC3960FF069A5: FAW signature in bits [63:8].
REQ-003 Parameter LOCK_COUNT, default 3: consecutive good FAWs needed to lock.
REQ-004 Parameter UNLOCK_COUNT, default 4: consecutive bad FAWs that drop lock.
REQ-005 Port clk_i  input  1: single clock; all logic in this domain.
REQ-006 Port rst_i  input  1: asynchronous, active-high reset.
REQ-007 Port s_axis_tdata_i  input  64: received word from the deserializer.
REQ-008 Port s_axis_tvalid_i  input  1: word strobe; no backpressure, no tready.
REQ-009 Port link_enable_i  input  1: low forces the block to SEARCH.
REQ-010 Port m_axis_tdata_o  output  64: recovered user data.
REQ-011 Port m_axis_tvalid_o  output  1: user data valid; no tready, the consumer always accepts.
REQ-012 Port locked_o  output  1: high in LOCKED.
REQ-013 Port remote_rx_rdy_o  output  1: FAW status bit0 from the last good FAW.
REQ-014 Port crc_error_o  output  1: one-cycle pulse on check-word mismatch.
REQ-015 Port faw_error_o  output  1: one-cycle pulse on a missing FAW while LOCKED.

Function
REQ-016 The block SHALL advance only on cycles with s_axis_tvalid_i=1; cycles with tvalid=0 hold all state and deassert the pulse outputs and m_axis_tvalid_o.
REQ-017 A word matches a FAW when s_axis_tdata_i[63:8]==FAW_PATTERN; bit0 is remote rx_rdy and bit1 is the frame-active flag.
REQ-018 The FSM SHALL have the states SEARCH, VERIFY and LOCKED.
REQ-019 SEARCH: a matching word moves the FSM to VERIFY, sets the position counter so the next word is position 1, and sets good_cnt=1.
REQ-020 The position counter SHALL increment per valid word and wrap from FAW_PERIOD-1 to 0.
REQ-021 VERIFY, position 0: on a match, good_cnt increments and the FSM goes to LOCKED when good_cnt reaches LOCK_COUNT; on a mismatch it returns to SEARCH.
REQ-022 LOCKED, position 0: a match clears miss_cnt, latches bit0 into remote_rx_rdy_o, and latches bit1 as the frame-active flag.
REQ-023 LOCKED, position 0: a mismatch pulses faw_error_o, increments miss_cnt and clears the frame-active flag; when miss_cnt reaches UNLOCK_COUNT the FSM goes to SEARCH.
REQ-024 At position 0, the XOR accumulator SHALL load zero.
REQ-025 At positions 1..FAW_PERIOD-2, the received word SHALL be XORed into the accumulator regardless of the frame-active flag.
REQ-026 At position FAW_PERIOD-1 in LOCKED, if the received word differs from the accumulator, crc_error_o SHALL pulse; crc_error_o SHALL not pulse in SEARCH or VERIFY.
REQ-027 In LOCKED with the frame-active flag set, each data-slot word SHALL appear on m_axis_tdata_o with m_axis_tvalid_o=1 exactly one cycle after input; the check word and FAW are never forwarded.
REQ-028 Data SHALL be forwarded before its frame check completes; crc_error_o flags the frame but does not retract data.
REQ-029 When link_enable_i=0, the block SHALL synchronously enter SEARCH, clear all counters, and deassert locked_o, remote_rx_rdy_o and m_axis_tvalid_o.
REQ-030 On leaving LOCKED, remote_rx_rdy_o and the frame-active flag SHALL clear in the same cycle as locked_o.
REQ-031 A FAW-pattern word at a data slot while LOCKED SHALL be treated as data; no re-alignment occurs.

Reset
REQ-032 rst_i=1 SHALL asynchronously force SEARCH, clear all counters and the accumulator, and drive every output to 0.
REQ-033 Reset release SHALL take effect on the first clk_i edge after rst_i falls; a mid-frame reset discards the partial frame.

Verification
REQ-034 Send 3 aligned frames with FAW bit1=1 and a correct XOR check word -> locked_o rises after the third FAW; the next frame's 62 data words are output with 1-cycle latency; crc_error_o stays 0.
REQ-035 When LOCKED, corrupt one data word after it is forwarded -> crc_error_o pulses exactly once at position 63; locked_o stays 1.
REQ-036 When LOCKED, corrupt 3 FAWs then send a good FAW -> 3 faw_error_o pulses, lock is held, miss_cnt resets; corrupting 4 consecutive FAWs -> locked_o=0 after the 4th.
REQ-037 Start the stream at word 17 with random tvalid gaps -> SEARCH ignores data until a FAW; after lock, output matches input order; gaps produce no output.
REQ-038 Deassert link_enable_i while LOCKED, then assert rst_i mid-frame -> all outputs 0 in the next cycle (link) or immediately (reset); relock requires 3 new FAWs.
REQ-039 Lock with FAW bit1=0 and bit0=1 -> remote_rx_rdy_o=1 and m_axis_tvalid_o never asserts.
